// File: rtl/risc_controller.sv
// risc_controller
//   Eight-phase instruction sequencer for the 8-bit RISC core. A free-running
//   3-bit phase counter steps through fetch (phases 0-3) and execute
//   (phases 4-7). A sticky halted flag freezes the sequencer at phase 4
//   after an HLT instruction. Only clr releases it.
//
// Ports
//   clk     : rising-edge clock
//   clr     : asynchronous active-low reset
//   opcode  : IR[7:5]; HLT=0 SKZ=1 ADD=2 AND=3 XOR=4 LDA=5 STO=6 JMP=7
//   zero    : accumulator == 0
//   sel     : address mux select (1 = PC, 0 = IR operand)
//   rd, wr  : memory read / write strobes
//   ld_ir   : instruction register load
//   inc_pc  : program counter increment
//   ld_pc   : program counter load
//   ld_ac   : accumulator load
//   data_e  : drive AC onto data bus
//   halt    : processor halted
//   phase   : current phase, for debug visibility
//
// State   | meaning
// --------+-------------------------------------------------------
// 0 INST_ADDR  | PC drives the address bus
// 1 INST_FETCH | instruction memory read
// 2 INST_LOAD  | IR captures the instruction
// 3 IDLE       | IR load held for a second edge
// 4 OP_ADDR    | PC advances past the instruction, or HLT stops here
// 5 OP_FETCH   | operand read for ALU-type opcodes
// 6 ALU_OP     | SKZ skip, JMP load, STO bus drive
// 7 STORE      | AC load, memory write, JMP completion
// halted       | frozen at 4 with only halt asserted

module risc_controller #(
  parameter int OPCODE_WIDTH = 3
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic                    zero,
  output logic                    sel,
  output logic                    rd,
  output logic                    ld_ir,
  output logic                    inc_pc,
  output logic                    ld_pc,
  output logic                    ld_ac,
  output logic                    wr,
  output logic                    data_e,
  output logic                    halt,
  output logic [2:0]              phase
);

  typedef enum logic [2:0] {
    PH_INST_ADDR  = 3'd0,
    PH_INST_FETCH = 3'd1,
    PH_INST_LOAD  = 3'd2,
    PH_IDLE       = 3'd3,
    PH_OP_ADDR    = 3'd4,
    PH_OP_FETCH   = 3'd5,
    PH_ALU_OP     = 3'd6,
    PH_STORE      = 3'd7
  } phase_e;

  localparam logic [OPCODE_WIDTH-1:0] OP_HLT = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_SKZ = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OP_AND = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OP_XOR = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] OP_LDA = OPCODE_WIDTH'(5);
  localparam logic [OPCODE_WIDTH-1:0] OP_STO = OPCODE_WIDTH'(6);
  localparam logic [OPCODE_WIDTH-1:0] OP_JMP = OPCODE_WIDTH'(7);

  phase_e phase_q, phase_d;
  logic   halted_q, halted_d;

  logic is_hlt, is_skz, is_sto, is_jmp, is_aluop;

  assign is_hlt   = (opcode == OP_HLT);
  assign is_skz   = (opcode == OP_SKZ);
  assign is_sto   = (opcode == OP_STO);
  assign is_jmp   = (opcode == OP_JMP);
  assign is_aluop = (opcode == OP_ADD) || (opcode == OP_AND) ||
                    (opcode == OP_XOR) || (opcode == OP_LDA);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      phase_q  <= PH_INST_ADDR;
      halted_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    phase_d  = phase_e'(phase_q + 3'd1);
    halted_d = halted_q;
    if (halted_q) begin
      phase_d = phase_q;
    end else if ((phase_q == PH_OP_ADDR) && is_hlt) begin
      // The halted flag is taken on the edge that would leave phase 4.
      phase_d  = PH_OP_ADDR;
      halted_d = 1'b1;
    end
  end

  // Opcode and zero appear only in the phase 4-7 arms, so the fetch phases
  // have no combinational dependence on them.
  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    halt   = 1'b0;
    if (halted_q) begin
      halt = 1'b1;
    end else begin
      unique case (phase_q)
        PH_INST_ADDR: begin
          sel = 1'b1;
        end
        PH_INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        PH_INST_LOAD, PH_IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        PH_OP_ADDR: begin
          halt   = is_hlt;
          inc_pc = !is_hlt;
        end
        PH_OP_FETCH: begin
          rd = is_aluop;
        end
        PH_ALU_OP: begin
          rd     = is_aluop;
          inc_pc = is_skz && zero;
          ld_pc  = is_jmp;
          data_e = is_sto;
        end
        PH_STORE: begin
          rd     = is_aluop;
          ld_ac  = is_aluop;
          inc_pc = is_jmp;
          ld_pc  = is_jmp;
          wr     = is_sto;
          data_e = is_sto;
        end
        default: ;
      endcase
    end
  end

  assign phase = phase_q;

endmodule
